// File: rtl/serial_abs_negate_pkg.sv
// Shared definitions for the bit-serial negate / absolute-value unit.
//   state_t : FSM state encoding (IDLE, SHIFT, DONE)
//   OP_NEG  : operation code for -x
//   OP_ABS  : operation code for |x|
package serial_abs_negate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic OP_NEG = 1'b0;
    localparam logic OP_ABS = 1'b1;

endpackage

// File: rtl/serial_abs_negate_bit.sv
// One-bit serial two's-complement negation cell.
// Bits are copied up to and including the first 1 seen, and inverted after it.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : one-cycle pulse that clears the seen-one flag for a new operand
//   en       : advance the flag on this cycle's bit
//   doNeg    : 1 = negate the stream, 0 = pass it through unchanged
//   b        : current input bit (LSB first)
//   r        : output bit for this cycle
module serial_negate_bit (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic en,
    input  logic doNeg,
    input  logic b,
    output logic r
);

    logic seenOne;
    logic flip;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            seenOne <= 1'b0;
        end else if (en && b) begin
            seenOne <= 1'b1;
        end
    end

    // r = b ^ (doNeg & seenOne): the flag is the pre-update value, so the
    // first 1 itself passes through unchanged.
    and gFlip (flip, doNeg, seenOne);
    xor gOut  (r, b, flip);

endmodule

// File: rtl/serial_abs_negate.sv
// Bit-serial two's-complement negate / absolute value.
// An operand is accepted over a valid/ready handshake, processed LSB first one
// bit per clock, and the result is held on the output until it is taken.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid, once raised, stays high with stable data until that edge.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   in_valid  : operand offered          in_ready  : operand can be accepted
//   in_data   : signed operand x         in_op     : 0 = -x, 1 = |x|
//   out_valid : result held and valid    out_ready : consumer takes result
//   out_data  : result                   out_sign  : sign bit of accepted x
//   out_ovf   : result not representable (most-negative input, negated)
//   dbgState  : current FSM state, for observation only
module serial_abs_negate
    import serial_abs_negate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sign,
    output logic             out_ovf,
    output logic [1:0]       dbgState
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shiftReg;
    logic [WIDTH-1:0] resultReg;
    logic             doNeg;
    logic             signReg;
    logic             ovfReg;
    logic             outValid;
    logic [WIDTH-1:0] outData;
    logic             outSign;
    logic             outOvf;

    logic accept;
    logic startNeg;
    logic bitOut;

    assign accept   = (state == ST_IDLE) && in_valid;
    // Negate is needed for op=NEG, or for op=ABS on a negative operand.
    assign startNeg = (in_op == OP_NEG) || in_data[WIDTH-1];

    serial_negate_bit uBit (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .en    (state == ST_SHIFT),
        .doNeg (doNeg),
        .b     (shiftReg[0]),
        .r     (bitOut)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            shiftReg  <= '0;
            resultReg <= '0;
            doNeg     <= 1'b0;
            signReg   <= 1'b0;
            ovfReg    <= 1'b0;
            outValid  <= 1'b0;
            outData   <= '0;
            outSign   <= 1'b0;
            outOvf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shiftReg <= in_data;
                        signReg  <= in_data[WIDTH-1];
                        doNeg    <= startNeg;
                        ovfReg   <= startNeg && (in_data == MOST_NEG);
                        count    <= CW'(WIDTH - 1);
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shiftReg  <= shiftReg >> 1;
                    // Fill from the MSB side so the first bit lands in bit 0.
                    resultReg <= {bitOut, resultReg[WIDTH-1:1]};
                    count     <= count - 1'b1;
                    if (count == '0) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle publishes the result; the outputs are
                    // only ever loaded here, so no partial value is visible.
                    if (!outValid) begin
                        outValid <= 1'b1;
                        outData  <= resultReg;
                        outSign  <= signReg;
                        outOvf   <= ovfReg;
                    end else if (out_ready) begin
                        outValid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = outValid;
    assign out_data  = outData;
    assign out_sign  = outSign;
    assign out_ovf   = outOvf;
    assign dbgState  = state;

endmodule

// File: tb/tb_serial_abs_negate.sv
module tb_serial_abs_negate;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_sign;
    logic         out_ovf;
    logic [1:0]   dbgState;

    int numChecks = 0;
    int numErrors = 0;

    // expected {ovf, sign, data}
    logic [W+1:0] expQ[$];

    serial_abs_negate #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sign  (out_sign),
        .out_ovf   (out_ovf),
        .dbgState  (dbgState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain signed integer arithmetic, then reduce mod 2^W.
    function automatic logic [W+1:0] refModel(input logic [W-1:0] x, input logic op);
        int v;
        int r;
        logic [W-1:0] d;
        logic ovf;
        v = x[W-1] ? int'(x) - (1 << W) : int'(x);
        if (op == 1'b0 || v < 0) r = -v;
        else                     r = v;
        ovf = (r > (1 << (W - 1)) - 1);
        d = W'(r);
        return {ovf, (v < 0), d};
    endfunction

    // driver: one full operation, with `stall` cycles of backpressure
    task automatic runOp(input logic [W-1:0] x, input logic op, input int stall);
        int waitCnt;
        int lat;
        logic [W+1:0] exp;
        in_data   = x;
        in_op     = op;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        waitCnt   = 0;
        while (!in_ready && waitCnt < 50) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (!in_ready) begin
            checkVal("acceptTimeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // accepted; later changes on the inputs must not matter
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_op    = 1'($urandom);
        expQ.push_back(refModel(x, op));
        lat = 0;
        while (!out_valid && lat < 40) begin
            checkVal("inReadyBusy", 32'(in_ready), 32'd0);
            out_ready = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        checkVal("latency", lat, W + 1);
        exp = expQ.pop_front();
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            checkVal("stallValid", 32'(out_valid), 32'd1);
            checkVal("stallResult", 32'({out_ovf, out_sign, out_data}), 32'(exp));
            checkVal("stallInReady", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkVal("result", 32'({out_ovf, out_sign, out_data}), 32'(exp));
        checkVal("outValid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkVal("validPulse", 32'(out_valid), 32'd0);
        checkVal("inReadyBack", 32'(in_ready), 32'd1);
    endtask

    task automatic checkIdleZero(input string tag);
        checkVal({tag, "_inReady"}, 32'(in_ready), 32'd1);
        checkVal({tag, "_outValid"}, 32'(out_valid), 32'd0);
        checkVal({tag, "_outs"}, 32'({out_ovf, out_sign, out_data}), 32'd0);
        checkVal({tag, "_state"}, 32'(dbgState), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleZero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // directed cases
        runOp(8'h05, 1'b0, 0);
        runOp(8'hFB, 1'b1, 0);
        runOp(8'h2A, 1'b1, 0);
        runOp(8'h00, 1'b0, 0);
        runOp(8'h80, 1'b1, 0);
        runOp(8'h80, 1'b0, 0);
        runOp(8'h7F, 1'b0, 5);

        // reset on the 4th SHIFT cycle discards the operation
        in_data  = 8'h33;
        in_op    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkIdleZero("midReset");
        runOp(8'h01, 1'b0, 0);

        // random operands, ops and stalls
        for (int i = 0; i < 40; i++) begin
            runOp(W'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        // full sweep of both ops
        for (int x = 0; x < (1 << W); x++) begin
            for (int op = 0; op < 2; op++) begin
                runOp(W'(x), 1'(op), $urandom_range(0, 1));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
